fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch sequencer: fetches one word, hands it to decode,
// waits for execution to finish, then computes the next PC (sequential or branch).
module fetch_unit #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned IW       = 9,
    parameter int unsigned START_PC = 0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [IW-1:0]   imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [IW-1:0]   instr,
    output logic [PC_W-1:0] instr_pc,
    input  logic            exec_done,
    input  logic            br_en,
    input  logic            br_out,
    input  logic [7:0]      br_offset,
    input  logic            halt,
    output logic            halted,
    output logic [15:0]     instr_count
);

    localparam logic [PC_W-1:0] StartPc = PC_W'(START_PC);

    typedef enum logic [2:0] {StIdle, StFetch, StIssue, StExec, StHalted} state_e;

    state_e          r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_instr_pc;
    logic [IW-1:0]   r_instr;
    logic [15:0]     r_count;
    logic            r_imem_req;
    logic            r_instr_valid;
    logic            r_halted;

    logic [PC_W-1:0] w_off_ext;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_seq_target;
    logic            w_taken;

    // Sign-extend (or truncate) the 8-bit offset to PC width; sums wrap modulo 2^PC_W.
    assign w_off_ext    = PC_W'($signed(br_offset));
    assign w_br_target  = r_instr_pc + w_off_ext;
    assign w_seq_target = r_instr_pc + PC_W'(1);
    assign w_taken      = br_en & br_out;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_pc          <= StartPc;
            r_instr_pc    <= '0;
            r_instr       <= '0;
            r_count       <= '0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StHalted: begin
                    if (start) begin
                        r_pc       <= StartPc;
                        r_count    <= '0;
                        r_state    <= StFetch;
                        r_imem_req <= 1'b1;
                        r_halted   <= 1'b0;
                    end
                end
                StFetch: begin
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_instr_pc    <= r_pc;
                        r_state       <= StIssue;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end
                end
                StIssue: begin
                    if (instr_ready) begin
                        r_state       <= StExec;
                        r_instr_valid <= 1'b0;
                    end
                end
                StExec: begin
                    if (exec_done) begin
                        if (r_count != 16'hFFFF) begin
                            r_count <= r_count + 16'd1;
                        end
                        // Halt wins over any branch outcome and leaves the PC untouched.
                        if (halt) begin
                            r_state  <= StHalted;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc       <= w_taken ? w_br_target : w_seq_target;
                            r_state    <= StFetch;
                            r_imem_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state       <= StIdle;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign halted      = r_halted;
    assign instr_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized instruction
// streams, checked against a transaction-level PC/count model.
module tb_fetch_unit;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       imem_req;
    logic [9:0] imem_addr;
    logic       imem_ack;
    logic [8:0] imem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [8:0] instr;
    logic [9:0] instr_pc;
    logic       exec_done;
    logic       br_en;
    logic       br_out;
    logic [7:0] br_offset;
    logic       halt;
    logic       halted;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pc    = 0;
    int m_count = 0;

    fetch_unit #(
        .PC_W    (10),
        .IW      (9),
        .START_PC(0)
    ) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .exec_done  (exec_done),
        .br_en      (br_en),
        .br_out     (br_out),
        .br_offset  (br_offset),
        .halt       (halt),
        .halted     (halted),
        .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pc    = 0;
        m_count = 0;
        check_eq("start_req", 32'(imem_req), 32'd1);
        check_eq("start_addr", 32'(imem_addr), 32'(m_pc));
        check_eq("start_count", 32'(instr_count), 32'(m_count));
        check_eq("start_halted", 32'(halted), 32'd0);
    endtask

    // One full instruction; expects the DUT to be fetching from m_pc on entry.
    task automatic run_instr(input logic [8:0] data, input int ack_wait, input int ready_wait,
                             input int exec_wait, input logic ben, input logic bout,
                             input logic [7:0] off, input logic hlt);
        int fetch_pc;
        fetch_pc = m_pc;
        check_eq("fetch_req", 32'(imem_req), 32'd1);
        check_eq("fetch_addr", 32'(imem_addr), 32'(fetch_pc));
        exec_done = 1'b1;
        for (int i = 0; i < ack_wait; i++) begin
            tick();
            check_eq("fetch_wait_req", 32'(imem_req), 32'd1);
            check_eq("fetch_wait_valid", 32'(instr_valid), 32'd0);
        end
        exec_done  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 9'($urandom);
        check_eq("issue_valid", 32'(instr_valid), 32'd1);
        check_eq("issue_instr", 32'(instr), 32'(data));
        check_eq("issue_pc", 32'(instr_pc), 32'(fetch_pc));
        check_eq("issue_req", 32'(imem_req), 32'd0);
        start = 1'b1;
        for (int i = 0; i < ready_wait; i++) begin
            tick();
            check_eq("stall_valid", 32'(instr_valid), 32'd1);
            check_eq("stall_instr", 32'(instr), 32'(data));
        end
        start       = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("exec_valid", 32'(instr_valid), 32'd0);
        imem_ack = 1'b1;
        start    = 1'b1;
        for (int i = 0; i < exec_wait; i++) begin
            tick();
            check_eq("exec_req", 32'(imem_req), 32'd0);
        end
        imem_ack  = 1'b0;
        start     = 1'b0;
        exec_done = 1'b1;
        br_en     = ben;
        br_out    = bout;
        br_offset = off;
        halt      = hlt;
        tick();
        exec_done = 1'b0;
        br_en     = 1'b0;
        br_out    = 1'b0;
        halt      = 1'b0;
        if (m_count < 65535) m_count++;
        check_eq("retire_count", 32'(instr_count), 32'(m_count));
        if (hlt) begin
            check_eq("halt_halted", 32'(halted), 32'd1);
            check_eq("halt_req", 32'(imem_req), 32'd0);
        end else begin
            if (ben && bout) m_pc = (fetch_pc + int'($signed(off)) + 1024) % 1024;
            else m_pc = (fetch_pc + 1) % 1024;
            check_eq("next_req", 32'(imem_req), 32'd1);
            check_eq("next_addr", 32'(imem_addr), 32'(m_pc));
            check_eq("next_halted", 32'(halted), 32'd0);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        exec_done   = 1'b0;
        br_en       = 1'b0;
        br_out      = 1'b0;
        br_offset   = '0;
        halt        = 1'b0;
        tick();
        tick();
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", 32'(instr), 32'd0);
        check_eq("rst_instr_pc", 32'(instr_pc), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_count", 32'(instr_count), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'd0);
        reset_n = 1'b1;

        // Idle ignores stray acks and completions
        imem_ack  = 1'b1;
        exec_done = 1'b1;
        repeat (3) tick();
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        check_eq("idle_req", 32'(imem_req), 32'd0);
        check_eq("idle_valid", 32'(instr_valid), 32'd0);

        do_start();
        run_instr(9'h1A5, 2, 1, 1, 1'b0, 1'b0, 8'h00, 1'b0);
        run_instr(9'h011, 0, 0, 0, 1'b1, 1'b0, 8'h40, 1'b0);
        run_instr(9'h022, 1, 2, 3, 1'b0, 1'b1, 8'h40, 1'b0);
        check_eq("seq_count3", 32'(instr_count), 32'd3);
        check_eq("seq_addr3", 32'(imem_addr), 32'd3);

        run_instr(9'h033, 0, 0, 0, 1'b1, 1'b1, 8'h07, 1'b0);  // 3 -> 10
        run_instr(9'h044, 1, 0, 1, 1'b1, 1'b1, 8'hFB, 1'b0);  // 10 -> 5
        check_eq("br_back_addr", 32'(imem_addr), 32'd5);
        run_instr(9'h055, 0, 1, 0, 1'b1, 1'b1, 8'h05, 1'b0);  // 5 -> 10
        run_instr(9'h066, 0, 0, 2, 1'b1, 1'b0, 8'hFB, 1'b0);  // not taken -> 11
        check_eq("br_nt_addr", 32'(imem_addr), 32'd11);
        run_instr(9'h077, 0, 0, 0, 1'b1, 1'b1, 8'hF4, 1'b0);  // 11 -> 0x3FF
        run_instr(9'h088, 1, 1, 1, 1'b0, 1'b0, 8'h00, 1'b0);  // wrap -> 0
        check_eq("wrap_seq_addr", 32'(imem_addr), 32'd0);
        run_instr(9'h099, 0, 0, 0, 1'b1, 1'b1, 8'hFE, 1'b0);  // 0 -> 0x3FE
        run_instr(9'h0AA, 0, 0, 0, 1'b1, 1'b1, 8'h05, 1'b0);  // wrap -> 3
        check_eq("wrap_br_addr", 32'(imem_addr), 32'd3);

        run_instr(9'h1FF, 0, 0, 0, 1'b1, 1'b1, 8'h10, 1'b1);
        imem_ack  = 1'b1;
        exec_done = 1'b1;
        repeat (3) begin
            tick();
            check_eq("halted_hold", 32'(halted), 32'd1);
            check_eq("halted_noreq", 32'(imem_req), 32'd0);
        end
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        do_start();

        for (int n = 0; n < 60; n++) begin
            logic hlt;
            hlt = ($urandom_range(0, 9) == 0);
            run_instr(9'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 8'($urandom), hlt);
            if (hlt) do_start();
        end

        // Reset while an instruction is waiting in issue
        imem_ack   = 1'b1;
        imem_rdata = 9'h123;
        tick();
        imem_ack = 1'b0;
        check_eq("pre_rst_valid", 32'(instr_valid), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("mid_rst_valid", 32'(instr_valid), 32'd0);
        check_eq("mid_rst_req", 32'(imem_req), 32'd0);
        check_eq("mid_rst_instr", 32'(instr), 32'd0);
        check_eq("mid_rst_count", 32'(instr_count), 32'd0);
        imem_ack    = 1'b1;
        exec_done   = 1'b1;
        instr_ready = 1'b1;
        repeat (3) begin
            tick();
            check_eq("post_rst_req", 32'(imem_req), 32'd0);
            check_eq("post_rst_valid", 32'(instr_valid), 32'd0);
        end
        imem_ack    = 1'b0;
        exec_done   = 1'b0;
        instr_ready = 1'b0;
        do_start();
        run_instr(9'h0F0, 1, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
